// File: rtl/vip_seq_pkg.sv
// Shared types and constants for the video switch sequencer.
// Holds the sequencer state enum, default switch register addresses,
// the video packet type code and the one-hot select encoder.
package vip_seq_pkg;

  typedef enum logic [1:0] {
    S_GO,
    S_SEL,
    S_COMMIT,
    S_RUN
  } state_t;

  // Default register map of the switch control slave
  localparam int VIP_CTRL_ADDR   = 0;
  localparam int VIP_COMMIT_ADDR = 2;
  localparam int VIP_SEL_ADDR    = 4;

  // Packet type nibble carried on the SOP beat; 0 marks a video frame
  localparam logic [3:0] VIP_PKT_VIDEO = 4'h0;

  // Switch dout select value for input idx (bit idx set)
  function automatic logic [31:0] onehot_sel(input logic [1:0] idx);
    onehot_sel = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/vip_seq_frame_detect.sv
// Purpose: turns the snooped switch dout stream into a one-cycle frame pulse.
// Latency: 1 cycle from the accepted video SOP beat to frame.
// Backpressure: none; passive tap, a beat counts only when valid & ready.
// Ports: clock/reset (sync, active-high); snoop_valid/ready/sop/data tap in;
//        frame out (registered pulse per video-frame SOP).
module vip_seq_frame_detect
  import vip_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  snoop_valid,
  input  logic                  snoop_ready,
  input  logic                  snoop_sop,
  input  logic [DATA_WIDTH-1:0] snoop_data,
  output logic                  frame
);

  // Only the type nibble matters; the rest of the beat is pixel payload.
  logic unused_data;
  assign unused_data = ^snoop_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame <= 1'b0;
    end else begin
      frame <= snoop_valid & snoop_ready & snoop_sop &
               (snoop_data[3:0] == VIP_PKT_VIDEO);
    end
  end

endmodule

// File: rtl/vip_switch_sequencer.sv
// Purpose: Avalon-MM master that programs the video switch, rotating inputs
//          every DWELL_FRAMES frames or holding a host-forced input.
// Latency: write sequence GO/SEL/COMMIT, one cycle each when not stalled;
//          a new input is chosen 1 cycle after the frame pulse.
// Backpressure: each write holds address/data until av_waitrequest is low.
// Ports: clock/reset (sync, active-high); snoop_* dout tap; manual_en/sel
//        host override; av_* master port; cur_input, switched, busy status.
// Option: VIP_SEQ_TIMEOUT_EN adds an idle counter that forces an advance
//         after TIMEOUT_CYC frameless cycles.
module vip_switch_sequencer
  import vip_seq_pkg::*;
#(
`ifdef VIP_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYC  = 2**24,
`endif
  parameter int NUM_INPUTS   = 2,
  parameter int DWELL_FRAMES = 60,
  parameter int DATA_WIDTH   = 24,
  parameter int CTRL_ADDR    = VIP_CTRL_ADDR,
  parameter int COMMIT_ADDR  = VIP_COMMIT_ADDR,
  parameter int SEL_ADDR     = VIP_SEL_ADDR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  snoop_valid,
  input  logic                  snoop_ready,
  input  logic                  snoop_sop,
  input  logic [DATA_WIDTH-1:0] snoop_data,
  input  logic                  manual_en,
  input  logic [1:0]            manual_sel,
  output logic [4:0]            av_address,
  output logic                  av_write,
  output logic [31:0]           av_writedata,
  input  logic                  av_waitrequest,
  output logic [1:0]            cur_input,
  output logic                  switched,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DWELL_FRAMES + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       target;
  logic [1:0]       msel;
  logic [1:0]       next_input;
  logic             frame;
  logic             run;
  logic             dwell_hit;
  logic             timeout_hit;
  logic             manual_go;
  logic             auto_go;
  logic             commit_done;

  vip_seq_frame_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_frame_detect (
    .clock       (clock),
    .reset       (reset),
    .snoop_valid (snoop_valid),
    .snoop_ready (snoop_ready),
    .snoop_sop   (snoop_sop),
    .snoop_data  (snoop_data),
    .frame       (frame)
  );

  // Out-of-range manual selections fall back to input 0.
  assign msel       = ({1'b0, manual_sel} < 3'(NUM_INPUTS)) ? manual_sel : 2'd0;
  assign next_input = (cur_input == 2'(NUM_INPUTS - 1)) ? 2'd0 : cur_input + 2'd1;

  assign run       = (state == S_RUN);
  assign dwell_hit = frame & (frame_cnt == CNT_W'(DWELL_FRAMES - 1));
  // Manual override takes priority and also suppresses dwell/timeout advances.
  assign manual_go = run & manual_en & (msel != cur_input);
  assign auto_go   = run & ~manual_en & (dwell_hit | timeout_hit);

`ifdef VIP_SEQ_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = run & (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // Saturates at the limit so a held manual override cannot wrap it.
  always_ff @(posedge clock) begin
    if (reset || !run || frame) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Write strobe is gated by reset so it drops in the cycle reset is sampled.
  always_comb begin
    state_next   = state;
    av_write     = 1'b0;
    av_address   = 5'd0;
    av_writedata = 32'd0;
    case (state)
      S_GO: begin
        av_write     = 1'b1;
        av_address   = 5'(CTRL_ADDR);
        av_writedata = 32'd1;
        if (!av_waitrequest) state_next = S_SEL;
      end
      S_SEL: begin
        av_write     = 1'b1;
        av_address   = 5'(SEL_ADDR);
        av_writedata = onehot_sel(target);
        if (!av_waitrequest) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        av_write     = 1'b1;
        av_address   = 5'(COMMIT_ADDR);
        av_writedata = 32'd1;
        if (!av_waitrequest) state_next = S_RUN;
      end
      S_RUN: begin
        if (manual_go || auto_go) state_next = S_SEL;
      end
      default: state_next = S_GO;
    endcase
    if (reset) av_write = 1'b0;
  end

  assign commit_done = (state == S_COMMIT) & av_write & ~av_waitrequest;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_GO;
      frame_cnt <= '0;
      target    <= 2'd0;
      cur_input <= 2'd0;
      switched  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state    <= state_next;
      switched <= 1'b0;
      if (commit_done) begin
        cur_input <= target;
        switched  <= 1'b1;
        frame_cnt <= '0;
        busy      <= 1'b0;
      end
      // Frames are only counted in S_RUN; a held manual_en parks the count at 0.
      if (manual_go) begin
        target    <= msel;
        busy      <= 1'b1;
        frame_cnt <= '0;
      end else if (auto_go) begin
        target    <= next_input;
        busy      <= 1'b1;
        frame_cnt <= '0;
      end else if (run && manual_en) begin
        frame_cnt <= '0;
      end else if (run && frame) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vip_switch_sequencer.sv
// Bench for vip_switch_sequencer (NUM_INPUTS=2, DWELL_FRAMES=3).
// Accepted master writes are checked against a queue of expected writes;
// frame sequences come from a vector table, corner cases are hand-written.
module tb_vip_switch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        snoop_valid = 1'b0;
  logic        snoop_ready = 1'b1;
  logic        snoop_sop = 1'b0;
  logic [23:0] snoop_data = 24'd0;
  logic        manual_en = 1'b0;
  logic [1:0]  manual_sel = 2'd0;
  logic [4:0]  av_address;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_waitrequest = 1'b0;
  logic [1:0]  cur_input;
  logic        switched;
  logic        busy;

  always #5 clock = ~clock;

  vip_switch_sequencer #(
`ifdef VIP_SEQ_TIMEOUT_EN
    .TIMEOUT_CYC  (100),
`endif
    .NUM_INPUTS   (2),
    .DWELL_FRAMES (3),
    .DATA_WIDTH   (24)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .snoop_valid    (snoop_valid),
    .snoop_ready    (snoop_ready),
    .snoop_sop      (snoop_sop),
    .snoop_data     (snoop_data),
    .manual_en      (manual_en),
    .manual_sel     (manual_sel),
    .av_address     (av_address),
    .av_write       (av_write),
    .av_writedata   (av_writedata),
    .av_waitrequest (av_waitrequest),
    .cur_input      (cur_input),
    .switched       (switched),
    .busy           (busy)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] ptype;
    logic       rdy;
    logic       sw;
    logic [1:0] cur;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[13];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sw_seen = 0;
  int   sw_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called once per cycle at the falling edge: scoreboard for accepted writes.
  task automatic mon();
    wr_t e;
    if (!reset && av_write === 1'b1 && av_waitrequest === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                 av_address, av_writedata);
      end else begin
        e = exp_q.pop_front();
        if (av_address !== e.addr || av_writedata !== e.data) begin
          n_err++;
          $display("FAIL write_order: got addr %0d data %0h, required addr %0d data %0h",
                   av_address, av_writedata, e.addr, e.data);
        end
      end
    end
    if (switched === 1'b1) sw_seen++;
  endtask

  task automatic samp();
    @(negedge clock);
    mon();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc();
    samp();
    adv();
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic expect_switch(input logic [1:0] idx);
    push(5'd4, 32'd1 << idx);
    push(5'd2, 32'd1);
    sw_exp++;
  endtask

  task automatic beat(input logic [3:0] pt, input logic rdy);
    snoop_valid = 1'b1;
    snoop_ready = rdy;
    snoop_sop   = 1'b1;
    snoop_data  = {20'd0, pt};
    cyc();
    snoop_valid = 1'b0;
    snoop_ready = 1'b1;
    snoop_sop   = 1'b0;
    snoop_data  = 24'd0;
  endtask

  initial begin
    logic found;
    int   n;

    // ptype, ready, expect switch, cur_input afterwards
    tbl[0]  = '{4'h0, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 2'd0};
    tbl[2]  = '{4'h0, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{4'h0, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{4'h0, 1'b1, 1'b1, 2'd1};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{4'h0, 1'b1, 1'b0, 2'd1};
    tbl[7]  = '{4'h0, 1'b1, 1'b0, 2'd1};
    tbl[8]  = '{4'hF, 1'b1, 1'b0, 2'd1};
    tbl[9]  = '{4'h0, 1'b1, 1'b1, 2'd0};
    tbl[10] = '{4'h0, 1'b1, 1'b0, 2'd0};
    tbl[11] = '{4'h0, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{4'h0, 1'b1, 1'b1, 2'd1};

    // Reset state, then the power-up GO/SEL/COMMIT burst
    cyc();
    cyc();
    samp();
    chk("rst_av_write", 32'(av_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cur_input", 32'(cur_input), 32'd0);
    chk("rst_switched", 32'(switched), 32'd0);
    adv();
    reset = 1'b0;
    push(5'd0, 32'd1);
    expect_switch(2'd0);
    samp();
    chk("boot_go_addr", {26'd0, av_write, av_address}, {26'd0, 1'b1, 5'd0});
    adv();
    samp();
    chk("boot_sel_addr", {26'd0, av_write, av_address}, {26'd0, 1'b1, 5'd4});
    adv();
    samp();
    chk("boot_commit_addr", {26'd0, av_write, av_address}, {26'd0, 1'b1, 5'd2});
    adv();
    samp();
    chk("boot_switched", 32'(switched), 32'd1);
    chk("boot_busy", 32'(busy), 32'd0);
    chk("boot_cur_input", 32'(cur_input), 32'd0);
    adv();

    // Frame counting with control packets and non-accepted beats mixed in
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].sw) expect_switch(tbl[i].cur);
      beat(tbl[i].ptype, tbl[i].rdy);
      repeat (8) cyc();
      chk($sformatf("tbl%0d_cur_input", i), 32'(cur_input), 32'(tbl[i].cur));
    end

    // Stalled SEL write: six stable cycles, COMMIT only after release
    av_waitrequest = 1'b1;
    expect_switch(2'd0);
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    beat(4'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      samp();
      if (av_write) found = 1'b1;
      else adv();
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL stall_sel_start: got no write within 20 cycles, required SEL write");
      av_waitrequest = 1'b0;
    end else begin
      chk("stall_c1", {av_write, av_address, av_writedata}, {1'b1, 5'd4, 32'd1});
      for (int k = 2; k <= 5; k++) begin
        adv();
        samp();
        chk($sformatf("stall_c%0d", k), {av_write, av_address, av_writedata}, {1'b1, 5'd4, 32'd1});
      end
      adv();
      av_waitrequest = 1'b0;
      samp();
      chk("stall_c6", {av_write, av_address, av_writedata}, {1'b1, 5'd4, 32'd1});
      adv();
      samp();
      chk("stall_commit_next", {av_write, av_address}, {1'b1, 5'd2});
    end
    adv();
    repeat (6) cyc();
    chk("stall_cur_input", 32'(cur_input), 32'd0);

    // Manual override raised together with the dwell-expiring frame
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    expect_switch(2'd1);
    manual_en  = 1'b1;
    manual_sel = 2'd1;
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    chk("manual_cur_input", 32'(cur_input), 32'd1);
    for (int i = 0; i < 4; i++) begin
      beat(4'h0, 1'b1);
      repeat (8) cyc();
    end
    chk("manual_hold_cur_input", 32'(cur_input), 32'd1);
    // Invalid index falls back to input 0
    expect_switch(2'd0);
    manual_sel = 2'd3;
    repeat (8) cyc();
    chk("manual_invalid_sel", 32'(cur_input), 32'd0);
    // Release: counting restarts from zero
    manual_en  = 1'b0;
    manual_sel = 2'd0;
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    chk("resume_no_switch", 32'(cur_input), 32'd0);
    expect_switch(2'd1);
    beat(4'h0, 1'b1);
    repeat (8) cyc();
    chk("resume_switch", 32'(cur_input), 32'd1);

    // Reset while a SEL write is stalled
    av_waitrequest = 1'b1;
    manual_en  = 1'b1;
    manual_sel = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      samp();
      if (av_write) found = 1'b1;
      else adv();
    end
    chk("midrst_sel_pending", {31'd0, found}, 32'd1);
    if (found) adv();
    reset = 1'b1;
    samp();
    chk("midrst_write_drop", 32'(av_write), 32'd0);
    adv();
    manual_en      = 1'b0;
    av_waitrequest = 1'b0;
    cyc();
    reset = 1'b0;
    push(5'd0, 32'd1);
    expect_switch(2'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      samp();
      if (switched) found = 1'b1;
      else adv();
    end
    chk("midrst_restart", {31'd0, found}, 32'd1);
    chk("midrst_cur_input", 32'(cur_input), 32'd0);

`ifdef VIP_SEQ_TIMEOUT_EN
    // No frames at all: forced advance after the idle limit
    expect_switch(2'd1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      adv();
      samp();
      n++;
      if (av_write) found = 1'b1;
    end
    chk("timeout_delay", 32'(n), 32'd100);
    adv();
    repeat (8) cyc();
    chk("timeout_cur_input", 32'(cur_input), 32'd1);
`else
    // No frames at all: selection is held
    n = 0;
    adv();
    repeat (150) cyc();
    chk("stalled_hold_cur_input", 32'(cur_input), 32'd0);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("switched_pulses", 32'(sw_seen), 32'(sw_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
